fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 13 +
 rtl/fifo_wr_arb_rr_pick.sv | 30 +++
 rtl/fifo_wr_arb.sv | 112 +++++++++++
 tb/tb_fifo_wr_arb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and defaults for the FIFO write arbiter and its downstream FIFO.
package fifo_wr_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int DEF_DW         = 32;
  localparam int DEF_FIFO_DEPTH = 16;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = IW'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Credit-based round-robin burst arbiter feeding a synchronous FIFO write port.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int NREQ       = 4,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    fifo_wr_en,
  output logic [DW-1:0]           fifo_data_in,
  input  logic                    fifo_rd_en,
  input  logic                    fifo_full,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    ovf_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_t      state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt, grant_nxt;
  logic [BW-1:0]   beat_cnt, beat_nxt;
  logic [CW-1:0]   credits;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            accept, acc_last;
  logic [IW-1:0]   acc_idx;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    req_ready  = '0;
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
    beat_nxt   = beat_cnt;
    acc_idx    = (state == IDLE) ? pick_idx : grant_id;

    // Ready is gated by credits so the FIFO can never be overrun.
    if (!rst && credits != '0) begin
      if (state == IDLE) req_ready = pick_gnt;
      else               req_ready[grant_id] = 1'b1;
    end

    accept   = |(req_valid & req_ready);
    acc_last = req_last[acc_idx];

    if (accept) begin
      case (state)
        IDLE: begin
          grant_nxt = pick_idx;
          beat_nxt  = BW'(1);
          if (acc_last || MAX_BURST == 1) rr_ptr_nxt = IW'(wrap_inc(int'(pick_idx), NREQ));
          else                            state_nxt  = BURST;
        end
        BURST: begin
          beat_nxt = beat_cnt + BW'(1);
          if (acc_last || (beat_cnt + BW'(1)) == BW'(MAX_BURST)) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = IW'(wrap_inc(int'(grant_id), NREQ));
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      beat_cnt     <= '0;
      credits      <= CW'(FIFO_DEPTH);
      fifo_wr_en   <= 1'b0;
      fifo_data_in <= '0;
      ovf_err      <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      grant_id   <= grant_nxt;
      beat_cnt   <= beat_nxt;
      fifo_wr_en <= accept;
      if (accept) fifo_data_in <= req_data[acc_idx*DW +: DW];
      if (accept && !fifo_rd_en)
        credits <= credits - 1'b1;
      else if (!accept && fifo_rd_en && credits != CW'(FIFO_DEPTH))
        credits <= credits + 1'b1;
      ovf_err <= ovf_err | (fifo_wr_en & fifo_full);
    end
  end

  assign busy = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: queued expected writes checked by a monitor.
module tb_fifo_wr_arb;

  localparam int DW = 32, NREQ = 4, DEPTH = 16, MB = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic               fifo_wr_en;
  logic [DW-1:0]      fifo_data_in;
  logic               fifo_rd_en, fifo_full, force_full;
  logic [1:0]         grant_id;
  logic               busy, ovf_err;

  int n_vec = 0, n_err = 0;
  int occ;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_e;
  int gq[$];
  int rem[NREQ], bn[NREQ], blen[NREQ];
  bit en[NREQ];

  always #5 clk = ~clk;

  fifo_wr_arb #(.DW(DW), .NREQ(NREQ), .FIFO_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .fifo_rd_en(fifo_rd_en), .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy),
    .ovf_err(ovf_err)
  );

  // Downstream FIFO occupancy model; it is reset together with the arbiter.
  always @(posedge clk) begin
    if (rst) occ <= 0;
    else     occ <= occ + int'(fifo_wr_en) - int'(fifo_rd_en);
  end
  assign fifo_full = force_full | (occ >= DEPTH);

  function automatic void chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", nm, a, e);
    end
  endfunction

  always @(negedge clk) begin
    if (fifo_wr_en && !rst) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wr_unexpected got=%0h expected=none", fifo_data_in);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_data", 64'(fifo_data_in), 64'(mon_e));
      end
    end
  end

  function automatic logic [DW-1:0] mk(input int i, input int b);
    return 32'hA000_0000 | (32'(i) << 16) | 32'(b);
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && rem[i] > 0;
      req_last[i]  = ((bn[i] + 1) % blen[i]) == 0;
      req_data[i*DW +: DW] = mk(i, bn[i] + 1);
    end
  endtask

  task automatic cycle();
    logic [NREQ-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs[i]) begin gq.push_back(i); bn[i]++; rem[i]--; end
    drive();
  endtask

  task automatic clr_src();
    for (int i = 0; i < NREQ; i++) begin en[i] = 0; rem[i] = 0; bn[i] = 0; blen[i] = 1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_rd_en = 1'b0; force_full = 1'b0;
    clr_src(); drive();
    repeat (2) cycle();
    rst = 1'b0;
    gq.delete();
  endtask

  task automatic chk_seq(input string nm, input int n, input logic [31:0] seq);
    logic [31:0] act;
    act = '0;
    foreach (gq[k]) act = (act << 4) | 32'(gq[k]);
    chk(nm, {32'(gq.size()), act}, {32'(n), seq});
  endtask

  task automatic drain(input string nm);
    repeat (2) cycle();
    chk(nm, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [6:0] busy_exp;
    rst = 1'b1; fifo_rd_en = 1'b0; force_full = 1'b0;
    clr_src();
    for (int i = 0; i < NREQ; i++) begin en[i] = 1; rem[i] = 1; end
    drive();
    #1 chk("rst_ready_hold", 64'(req_ready), 64'd0);
    repeat (2) cycle();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_data", 64'(fifo_data_in), 64'd0);
    chk("rst_ovf", 64'(ovf_err), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);

    // Fairness: single-beat bursts rotate 0,1,2,3,0 back to back.
    do_reset();
    for (int i = 0; i < NREQ; i++) en[i] = 1;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
    exp_q.push_back(mk(0,1)); exp_q.push_back(mk(1,1)); exp_q.push_back(mk(2,1));
    exp_q.push_back(mk(3,1)); exp_q.push_back(mk(0,2));
    drive();
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("fair_wr_cont", 64'(fifo_wr_en), 64'd1);
    end
    chk_seq("fair_seq", 5, 32'h01230);
    drain("fair_drain");

    // Burst cap: req0 limited to 4 beats, req1 gets in before req0 resumes.
    do_reset();
    en[0] = 1; rem[0] = 6; blen[0] = 6;
    en[1] = 1; rem[1] = 1;
    for (int b = 1; b <= 4; b++) exp_q.push_back(mk(0,b));
    exp_q.push_back(mk(1,1)); exp_q.push_back(mk(0,5)); exp_q.push_back(mk(0,6));
    drive();
    busy_exp = 7'b0100111;
    for (int c = 0; c < 7; c++) begin
      cycle();
      chk("cap_busy", 64'(busy), 64'(busy_exp[c]));
      if (c == 4) chk("cap_grant1", 64'(grant_id), 64'd1);
    end
    chk_seq("cap_seq", 7, 32'h0000100);
    drain("cap_drain");

    // Credits: 16 beats fill the FIFO, then one read frees exactly one beat.
    do_reset();
    en[0] = 1; rem[0] = 20;
    for (int b = 1; b <= 19; b++) exp_q.push_back(mk(0,b));
    drive();
    repeat (16) cycle();
    chk("cred_fill", 64'(gq.size()), 64'd16);
    repeat (2) cycle();
    chk("cred_stall", 64'(gq.size()), 64'd16);
    chk("cred_ready0", 64'(req_ready), 64'd0);
    chk("cred_full", 64'(fifo_full), 64'd1);
    chk("cred_ovf0", 64'(ovf_err), 64'd0);
    fifo_rd_en = 1'b1;
    cycle();
    fifo_rd_en = 1'b0;
    repeat (3) cycle();
    chk("cred_one", 64'(gq.size()), 64'd17);

    // Read and accept together at one credit keeps the credit.
    fifo_rd_en = 1'b1;
    repeat (2) cycle();
    fifo_rd_en = 1'b0;
    repeat (2) cycle();
    chk("cred_rdacc", 64'(gq.size()), 64'd19);
    chk("cred_ready_end", 64'(req_ready), 64'd0);
    chk("cred_ovf_end", 64'(ovf_err), 64'd0);
    drain("cred_drain");

    // Reset mid-burst drops the burst and the pending write.
    do_reset();
    en[2] = 1; rem[2] = 4; blen[2] = 4;
    drive();
    cycle();
    chk("mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1 chk("mid_rst_ready", 64'(req_ready), 64'd0);
    cycle();
    rst = 1'b0;
    chk("mid_busy0", 64'(busy), 64'd0);
    chk("mid_wr0", 64'(fifo_wr_en), 64'd0);
    gq.delete();
    en[0] = 1; rem[0] = 1; en[1] = 1; rem[1] = 1;
    exp_q.push_back(mk(0,1)); exp_q.push_back(mk(1,1));
    exp_q.push_back(mk(2,2)); exp_q.push_back(mk(2,3)); exp_q.push_back(mk(2,4));
    drive();
    repeat (5) cycle();
    chk_seq("mid_seq", 5, 32'h01222);
    drain("mid_drain");

    // Overflow error is sticky until reset.
    do_reset();
    force_full = 1'b1;
    en[3] = 1; rem[3] = 1;
    exp_q.push_back(mk(3,1));
    drive();
    repeat (2) cycle();
    chk("ovf_set", 64'(ovf_err), 64'd1);
    force_full = 1'b0;
    repeat (3) cycle();
    chk("ovf_sticky", 64'(ovf_err), 64'd1);
    chk("ovf_drain", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    cycle();
    chk("ovf_clear", 64'(ovf_err), 64'd0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1);
  end

endmodule
